// File: rtl/miriscv_uart_rx.sv
// -----------------------------------------------------------------------------
// miriscv_uart_rx
//
// UART receiver for 8E1 frames: 1 start bit (0), 8 data bits LSB first,
// 1 even-parity bit (XOR of the data bits), 1 stop bit (1). Good bytes are
// stored in a receive buffer with a valid/ready pop interface; bad frames and
// dropped bytes are reported with single-cycle error pulses.
//
// Configuration macro:
//   MIRISCV_UART_RX_FIFO_EN  defined   -> 4-entry FIFO receive buffer
//                            undefined -> single holding register (depth 1)
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency in Hz
//   BAUDRATE     line rate; DIV = CLK_FREQ_HZ / BAUDRATE (legal 4..65535)
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   uart_rx_i     asynchronous serial line, idle high
//   rx_data_o     byte at the head of the receive buffer
//   rx_valid_o    buffer holds at least one byte
//   rx_ready_i    pops the head byte when high together with rx_valid_o
//   parity_err_o  one-cycle pulse: frame with bad parity discarded
//   frame_err_o   one-cycle pulse: frame with stop bit 0 discarded
//   overrun_o     one-cycle pulse: good byte dropped because buffer was full
// -----------------------------------------------------------------------------
module miriscv_uart_rx #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUDRATE    = 6250000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int unsigned      DIV      = CLK_FREQ_HZ / BAUDRATE;
    localparam int unsigned      CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    // -------------------------------------------------------------------------
    // Input synchronizer. Flops reset to 1 (idle line) so that releasing reset
    // on an idle line never looks like a start edge. rx_prev_q holds the
    // previous synchronized value for falling-edge detection.
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic rx_prev_q;
    logic rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= uart_rx_i;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    assign rx_s = sync2_q;

    // -------------------------------------------------------------------------
    // Receive FSM and datapath registers
    // -------------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             par_bit_q, par_bit_d;
    logic             stop_sample;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        stop_sample = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                end
            end

            // Re-check the line half a bit later; a line that is high again
            // was a glitch and is ignored silently.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // From the middle of the start bit, every DIV clocks lands in
            // the middle of the next bit.
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = rx_s;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Leave in the middle of the stop bit so a start edge directly
            // following the stop bit is not missed.
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame verdict. A bad stop bit dominates a parity mismatch.
    // -------------------------------------------------------------------------
    logic frame_bad;
    logic parity_bad;
    logic frame_good;
    logic buf_full;
    logic pop;
    logic push;

    assign frame_bad  = stop_sample && !rx_s;
    assign parity_bad = stop_sample &&  rx_s && (par_bit_q != ^shift_q);
    assign frame_good = stop_sample &&  rx_s && (par_bit_q == ^shift_q);

    assign pop  = rx_valid_o && rx_ready_i;
    // A pop in the same cycle frees the slot, so a full buffer can still
    // accept the new byte.
    assign push = frame_good && (!buf_full || pop);

    logic frame_err_q;
    logic parity_err_q;
    logic overrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= frame_bad;
            parity_err_q <= parity_bad;
            overrun_q    <= frame_good && buf_full && !pop;
        end
    end

    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;

    // -------------------------------------------------------------------------
    // Receive buffer
    // -------------------------------------------------------------------------
`ifdef MIRISCV_UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign buf_full   = (count_q == 3'd4);
    assign rx_valid_o = (count_q != 3'd0);
    assign rx_data_o  = mem_q[rd_ptr_q];
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            if (push) begin
                hold_q     <= shift_q;
                hold_vld_q <= 1'b1;
            end else if (pop) begin
                hold_vld_q <= 1'b0;
            end
        end
    end

    assign buf_full   = hold_vld_q;
    assign rx_valid_o = hold_vld_q;
    assign rx_data_o  = hold_q;
`endif

endmodule

// File: tb/tb_miriscv_uart_rx.sv
`timescale 1ns/1ps
module tb_miriscv_uart_rx;

    localparam int DIV = 16;
`ifdef MIRISCV_UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int K_PERR = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       ovr;

    miriscv_uart_rx #(
        .CLK_FREQ_HZ(100000000),
        .BAUDRATE   (6250000)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uart_rx_i   (uart_rx),
        .rx_data_o   (data),
        .rx_valid_o  (valid),
        .rx_ready_i  (ready),
        .parity_err_o(perr),
        .frame_err_o (ferr),
        .overrun_o   (ovr)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_bytes[$];
    int         exp_evt[$];
    int         ready_mode = 2;   // 0: hold low, 1: random, 2: always high
    bit         hold = 1'b0;
    int         model_occ = 0;

    // ---------------- helpers ----------------
    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_evt(input logic sig, input int kind, input string name);
        int k;
        if (sig) begin
            total++;
            if (exp_evt.size() == 0) begin
                bad++;
                $display("FAIL %s: got pulse, required no pulse", name);
            end else begin
                k = exp_evt.pop_front();
                if (k != kind) begin
                    bad++;
                    $display("FAIL %s: got event kind %0d, required kind %0d", name, kind, k);
                end
            end
        end
    endtask

    task automatic check_reset_outputs();
        check8("rst_data",  data,  8'h00);
        check1("rst_valid", valid, 1'b0);
        check1("rst_perr",  perr,  1'b0);
        check1("rst_ferr",  ferr,  1'b0);
        check1("rst_ovr",   ovr,   1'b0);
    endtask

    // Reference model: outcome of a frame from the framing rules alone.
    task automatic expect_frame(input logic [7:0] d, input logic p, input logic s);
        if (!s) begin
            exp_evt.push_back(K_FERR);
        end else if (p != ^d) begin
            exp_evt.push_back(K_PERR);
        end else if (hold) begin
            if (model_occ < DEPTH) begin
                exp_bytes.push_back(d);
                model_occ++;
            end else begin
                exp_evt.push_back(K_OVR);
            end
        end else begin
            exp_bytes.push_back(d);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        expect_frame(d, p, s);
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_rx = bits[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic wait_done(input bit need_bytes);
        int n;
        n = 0;
        while ((exp_evt.size() != 0 || (need_bytes && exp_bytes.size() != 0)) && n < 600) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 600) begin
            bad++;
            $display("FAIL drain_timeout: got pending events=%0d bytes=%0d, required 0",
                     exp_evt.size(), exp_bytes.size());
        end
        repeat (4 * DIV) @(negedge clk);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       ready = 1'b0;
                1:       ready = ($urandom_range(0, 3) != 0);
                default: ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] prev_data = 8'h00;
    bit         prev_hold = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && valid) begin
                    check8("data_stable", data, prev_data);
                end
                if (valid && ready) begin
                    if (exp_bytes.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_byte: got 0x%02h, required no byte", data);
                    end else begin
                        check8("rx_byte", data, exp_bytes.pop_front());
                    end
                end
                check_evt(perr, K_PERR, "parity_err");
                check_evt(ferr, K_FERR, "frame_err");
                check_evt(ovr,  K_OVR,  "overrun");
                prev_hold = valid && !ready;
                prev_data = data;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (2 * DIV) @(negedge clk);

        // good byte, parity error, frame error followed by good byte
        ready_mode = 2;
        send_frame(8'h55, 1'b0, 1'b1);
        wait_done(1'b1);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_done(1'b1);
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (DIV) @(negedge clk);
        send_frame(8'h11, 1'b0, 1'b1);
        wait_done(1'b1);

        // 60 ns glitch on idle line, then a normal frame
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_done(1'b1);

        // overrun: consumer stalled, five back-to-back frames
        ready_mode = 0;
        hold       = 1'b1;
        model_occ  = 0;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_frame(d, ^d, 1'b1);
        end
        wait_done(1'b0);
        check1("held_valid", valid, 1'b1);
        check8("held_head", data, 8'h01);
        hold       = 1'b0;
        ready_mode = 1;
        wait_done(1'b1);

        // reset in the middle of 0xFF (during bit 4)
        ready_mode = 2;
        repeat (4) @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * DIV + DIV / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (8 * DIV) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_done(1'b1);

        // randomized frames with random consumer backpressure
        ready_mode = 1;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            p = ^d;
            if ($urandom_range(0, 4) == 0) p = ~p;
            s = ($urandom_range(0, 6) != 0);
            send_frame(d, p, s);
            if (!s) repeat (DIV) @(negedge clk);
        end
        wait_done(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
